// File: rtl/dst_memory_writer.sv
// rtl/dst_memory_writer.sv - buffered result writer into an 8x8 destination memory with read-back and sweep-clear
// Optional macro DST_MEM_FORWARD_EN: read port becomes write-first for same-cycle commits and clears.
module dst_memory_writer #(
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 3,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [DATA_W-1:0] dst_value,
   input  logic              clr_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_value,
   output logic              busy,
   output logic [7:0]        commit_count
);

   localparam int DEPTH  = 1 << ADDR_W;
   localparam int FIDX_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
   localparam int PTR_W  = FIDX_W + 1;

   localparam logic       ST_IDLE  = 1'b0;
   localparam logic       ST_CLEAR = 1'b1;
   localparam logic [ADDR_W-1:0] SWEEP_LAST = ADDR_W'(DEPTH - 1);

   logic              state_q, state_d;
   logic [ADDR_W-1:0] sweep_q, sweep_d;
   logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
   logic [ADDR_W-1:0] fifo_addr_d [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data_d [FIFO_DEPTH];
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DATA_W-1:0] rd_value_q, rd_value_d;
   logic [7:0]        commit_count_q, commit_count_d;

   logic              fifo_full, fifo_empty, accept, commit, clearing;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;

   assign fifo_empty = (wptr_q == rptr_q);
   assign fifo_full  = (wptr_q[FIDX_W-1:0] == rptr_q[FIDX_W-1:0]) &&
                       (wptr_q[PTR_W-1] != rptr_q[PTR_W-1]);
   assign accept     = wr_valid && !fifo_full;
   assign clearing   = (state_q == ST_CLEAR);
   // A clear request beats a pending commit; the entry waits in the FIFO.
   assign commit     = (state_q == ST_IDLE) && !clr_req && !fifo_empty;
   assign head_addr  = fifo_addr_q[rptr_q[FIDX_W-1:0]];
   assign head_data  = fifo_data_q[rptr_q[FIDX_W-1:0]];

   assign wr_ready     = !fifo_full;
   assign busy         = !fifo_empty || clearing;
   assign rd_value     = rd_value_q;
   assign commit_count = commit_count_q;

   always_comb begin
      state_d        = state_q;
      sweep_d        = sweep_q;
      wptr_d         = wptr_q;
      rptr_d         = rptr_q;
      fifo_addr_d    = fifo_addr_q;
      fifo_data_d    = fifo_data_q;
      mem_d          = mem_q;
      commit_count_d = commit_count_q;

      if (accept) begin
         fifo_addr_d[wptr_q[FIDX_W-1:0]] = dst_addr;
         fifo_data_d[wptr_q[FIDX_W-1:0]] = dst_value;
         wptr_d = wptr_q + PTR_W'(1);
      end

      if (clearing) begin
         mem_d[sweep_q] = '0;
         sweep_d        = sweep_q + ADDR_W'(1);
         if (sweep_q == SWEEP_LAST) begin
            state_d = ST_IDLE;
         end
      end else if (clr_req) begin
         state_d = ST_CLEAR;
         sweep_d = '0;
      end else if (commit) begin
         mem_d[head_addr] = head_data;
         rptr_d           = rptr_q + PTR_W'(1);
         commit_count_d   = commit_count_q + 8'd1;
      end
   end

   always_comb begin
      rd_value_d = mem_q[rd_addr];
`ifdef DST_MEM_FORWARD_EN
      if (commit && (head_addr == rd_addr)) begin
         rd_value_d = head_data;
      end else if (clearing && (sweep_q == rd_addr)) begin
         rd_value_d = '0;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         sweep_q        <= '0;
         wptr_q         <= '0;
         rptr_q         <= '0;
         fifo_addr_q    <= '{default: '0};
         fifo_data_q    <= '{default: '0};
         mem_q          <= '{default: '0};
         rd_value_q     <= '0;
         commit_count_q <= '0;
      end else begin
         state_q        <= state_d;
         sweep_q        <= sweep_d;
         wptr_q         <= wptr_d;
         rptr_q         <= rptr_d;
         fifo_addr_q    <= fifo_addr_d;
         fifo_data_q    <= fifo_data_d;
         mem_q          <= mem_d;
         rd_value_q     <= rd_value_d;
         commit_count_q <= commit_count_d;
      end
   end

endmodule
